// File: rtl/vga_driver_pkg.sv
// Shared 640x480@60 timing defaults, colour word layout and small decode helpers
// for the VGA timing master.
package vga_driver_pkg;

  localparam int XY_W    = 10;
  localparam int COLOR_W = 24;
  localparam int CH_W    = 8;

  localparam int DEF_CLK_DIV  = 2;
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;
  localparam int DEF_PIPE_DLY = 1;

  // {R,G,B}: red occupies the top byte of the colour word
  typedef struct packed {
    logic [CH_W-1:0] r;
    logic [CH_W-1:0] g;
    logic [CH_W-1:0] b;
  } rgb_t;

  typedef struct packed {
    logic hs;
    logic vs;
    logic act;
  } sync_t;

  localparam sync_t SYNC_IDLE = '{hs: 1'b1, vs: 1'b1, act: 1'b0};

  function automatic rgb_t unpack_rgb(input logic [COLOR_W-1:0] c);
    return rgb_t'(c);
  endfunction

  function automatic logic in_span(input logic [XY_W-1:0] v, input int lo, input int len);
    return (int'(v) >= lo) && (int'(v) < lo + len);
  endfunction

endpackage

// File: rtl/vga_driver_if.sv
// Pixel-side and DAC-side signals of the VGA driver; master is the driver,
// slave is the colour logic / board pins.
interface vga_driver_if;
  import vga_driver_pkg::*;

  logic [XY_W-1:0]    x;
  logic [XY_W-1:0]    y;
  logic               pix_en;
  logic               frame_start;
  logic [COLOR_W-1:0] color;
  logic               vga_clk;
  logic               vga_hs;
  logic               vga_vs;
  logic               vga_blank_n;
  logic               vga_sync_n;
  logic [CH_W-1:0]    vga_r;
  logic [CH_W-1:0]    vga_g;
  logic [CH_W-1:0]    vga_b;

  modport master (
    output x, y, pix_en, frame_start,
    output vga_clk, vga_hs, vga_vs, vga_blank_n, vga_sync_n, vga_r, vga_g, vga_b,
    input  color
  );

  modport slave (
    input  x, y, pix_en, frame_start,
    input  vga_clk, vga_hs, vga_vs, vga_blank_n, vga_sync_n, vga_r, vga_g, vga_b,
    output color
  );

endinterface

// File: rtl/vga_sync_delay.sv
// Enable-gated shift register of configurable width/depth; DEPTH=0 is a wire.
// Resets to the IDLE word so no stale sync pulse leaks out after reset.
module vga_sync_delay #(
  parameter int               WIDTH = 3,
  parameter int               DEPTH = 1,
  parameter logic [WIDTH-1:0] IDLE  = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  if (DEPTH == 0) begin : g_bypass
    logic unused_ctrl;
    assign unused_ctrl = clk ^ rst ^ en;
    assign q = d;
  end else begin : g_line
    logic [WIDTH-1:0] line_q [DEPTH];
    logic [WIDTH-1:0] line_d [DEPTH];

    always_comb begin
      line_d = line_q;
      if (en) begin
        line_d[0] = d;
        for (int i = 1; i < DEPTH; i++) begin
          line_d[i] = line_q[i-1];
        end
      end
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        for (int i = 0; i < DEPTH; i++) begin
          line_q[i] <= IDLE;
        end
      end else begin
        line_q <= line_d;
      end
    end

    assign q = line_q[DEPTH-1];
  end

endmodule

// File: rtl/vga_driver.sv
// VGA timing master and pixel sink: pixel divider, h/v counters, sync/blank
// decode, and DAC output registers aligned to the colour pipeline.
module vga_driver
  import vga_driver_pkg::*;
#(
  parameter int CLK_DIV  = DEF_CLK_DIV,
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter int PIPE_DLY = DEF_PIPE_DLY
) (
  input logic          clk,
  input logic          rst,
  vga_driver_if.master vga
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = $clog2(CLK_DIV);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);
  localparam logic [XY_W-1:0]  X_LAST   = XY_W'(H_TOTAL - 1);
  localparam logic [XY_W-1:0]  Y_LAST   = XY_W'(V_TOTAL - 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic [XY_W-1:0]  x_q, x_d;
  logic [XY_W-1:0]  y_q, y_d;
  logic             pix_en_q, pix_en_d;
  logic             frame_start_q, frame_start_d;
  logic             vga_clk_q, vga_clk_d;
  sync_t            sync_raw, sync_dly;
  sync_t            out_q, out_d;
  rgb_t             rgb_q, rgb_d;

  // Divider and counters. Strobes are computed from next-state so they line
  // up with the clock on which the counters actually advance.
  always_comb begin
    div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
    x_d   = x_q;
    y_d   = y_q;
    if (pix_en_q) begin
      if (x_q == X_LAST) begin
        x_d = '0;
        y_d = (y_q == Y_LAST) ? '0 : y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
      end
    end
    pix_en_d      = (div_d == DIV_LAST);
    frame_start_d = pix_en_d && (x_d == '0) && (y_d == '0);
    vga_clk_d     = (div_d >= DIV_HALF);
  end

  always_comb begin
    sync_raw.hs  = !in_span(x_q, H_ACTIVE + H_FP, H_SYNC);
    sync_raw.vs  = !in_span(y_q, V_ACTIVE + V_FP, V_SYNC);
    sync_raw.act = (int'(x_q) < H_ACTIVE) && (int'(y_q) < V_ACTIVE);
  end

  vga_sync_delay #(
    .WIDTH ($bits(sync_t)),
    .DEPTH (PIPE_DLY),
    .IDLE  (SYNC_IDLE)
  ) u_sync_delay (
    .clk (clk),
    .rst (rst),
    .en  (pix_en_q),
    .d   (sync_raw),
    .q   (sync_dly)
  );

  // Output stage: colour is only looked at on pixel ticks.
  always_comb begin
    out_d = out_q;
    rgb_d = rgb_q;
    if (pix_en_q) begin
      out_d = sync_dly;
      rgb_d = sync_dly.act ? unpack_rgb(vga.color) : '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_q         <= '0;
      x_q           <= '0;
      y_q           <= '0;
      pix_en_q      <= 1'b0;
      frame_start_q <= 1'b0;
      vga_clk_q     <= 1'b0;
      out_q         <= SYNC_IDLE;
      rgb_q         <= '0;
    end else begin
      div_q         <= div_d;
      x_q           <= x_d;
      y_q           <= y_d;
      pix_en_q      <= pix_en_d;
      frame_start_q <= frame_start_d;
      vga_clk_q     <= vga_clk_d;
      out_q         <= out_d;
      rgb_q         <= rgb_d;
    end
  end

  assign vga.x           = x_q;
  assign vga.y           = y_q;
  assign vga.pix_en      = pix_en_q;
  assign vga.frame_start = frame_start_q;
  assign vga.vga_clk     = vga_clk_q;
  assign vga.vga_hs      = out_q.hs;
  assign vga.vga_vs      = out_q.vs;
  assign vga.vga_blank_n = out_q.act;
  assign vga.vga_sync_n  = 1'b0;
  assign vga.vga_r       = rgb_q.r;
  assign vga.vga_g       = rgb_q.g;
  assign vga.vga_b       = rgb_q.b;

endmodule
